// File: rtl/scan_pkg.sv
`default_nettype none
// ============================================================================
// Module      : scan_pkg
// Description : Shared TAP state encoding, IR constants and TAP next-state.
// Revision    : 1.0 - initial release
// ============================================================================
package scan_pkg;

  // Standard 1149.1 state encoding
  typedef enum logic [3:0] {
    EXIT2_DR   = 4'h0,
    EXIT1_DR   = 4'h1,
    SHIFT_DR   = 4'h2,
    PAUSE_DR   = 4'h3,
    SELECT_IR  = 4'h4,
    UPDATE_DR  = 4'h5,
    CAPTURE_DR = 4'h6,
    SELECT_DR  = 4'h7,
    EXIT2_IR   = 4'h8,
    EXIT1_IR   = 4'h9,
    SHIFT_IR   = 4'hA,
    PAUSE_IR   = 4'hB,
    RTI        = 4'hC,
    UPDATE_IR  = 4'hD,
    CAPTURE_IR = 4'hE,
    TLR        = 4'hF
  } tap_state_t;

  localparam logic [7:0] IR_CAPTURE = 8'h01;
  localparam logic [7:0] IR_RESET   = 8'hFF;

  function automatic tap_state_t tap_next(input tap_state_t s, input logic tms);
    tap_state_t n;
    case (s)
      TLR:        n = tms ? TLR        : RTI;
      RTI:        n = tms ? SELECT_DR  : RTI;
      SELECT_DR:  n = tms ? SELECT_IR  : CAPTURE_DR;
      CAPTURE_DR: n = tms ? EXIT1_DR   : SHIFT_DR;
      SHIFT_DR:   n = tms ? EXIT1_DR   : SHIFT_DR;
      EXIT1_DR:   n = tms ? UPDATE_DR  : PAUSE_DR;
      PAUSE_DR:   n = tms ? EXIT2_DR   : PAUSE_DR;
      EXIT2_DR:   n = tms ? UPDATE_DR  : SHIFT_DR;
      UPDATE_DR:  n = tms ? SELECT_DR  : RTI;
      SELECT_IR:  n = tms ? TLR        : CAPTURE_IR;
      CAPTURE_IR: n = tms ? EXIT1_IR   : SHIFT_IR;
      SHIFT_IR:   n = tms ? EXIT1_IR   : SHIFT_IR;
      EXIT1_IR:   n = tms ? UPDATE_IR  : PAUSE_IR;
      PAUSE_IR:   n = tms ? EXIT2_IR   : PAUSE_IR;
      EXIT2_IR:   n = tms ? UPDATE_IR  : SHIFT_IR;
      UPDATE_IR:  n = tms ? SELECT_DR  : RTI;
      default:    n = TLR;
    endcase
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tck_sync.sv
`default_nettype none
// ============================================================================
// Module      : tck_sync
// Description : Multi-flop synchronizer plus one delay register and edge flags.
// Revision    : 1.0 - initial release
// ============================================================================
module tck_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_s,
  output logic o_d,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   dly_q, dly_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], i_d};
    dly_d  = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      dly_q  <= RESET_VAL;
    end else begin
      sync_q <= sync_d;
      dly_q  <= dly_d;
    end
  end

  assign o_s    = sync_q[SYNC_STAGES-1];
  assign o_d    = dly_q;
  assign o_rise = o_s & ~o_d;
  assign o_fall = ~o_s & o_d;

endmodule
`default_nettype wire

// File: rtl/scan_responder.sv
`default_nettype none
// ============================================================================
// Module      : scan_responder
// Description : Oversampled TAP responder slot: IR/DR exchange or 1-bit bypass.
// Revision    : 1.0 - initial release
// ============================================================================
module scan_responder
  import scan_pkg::*;
#(
  parameter int IO_WIDTH    = 8,
  parameter int ADDR_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_tck,
  input  logic                  i_tms,
  input  logic                  i_tdi,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [IO_WIDTH-1:0]   inbound,
  output logic [IO_WIDTH-1:0]   outbound,
  output logic                  o_tck,
  output logic                  o_tms,
  output logic                  o_tdo
);

  logic tck_s, tck_d, tck_rise, tck_fall;
  logic tms_s, tms_d, tms_rise_unused, tms_fall_unused;
  logic tdi_s, tdi_d_unused, tdi_rise_unused, tdi_fall_unused;

  tck_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_tck_sync (
    .clk(clk), .reset(reset), .i_d(i_tck),
    .o_s(tck_s), .o_d(tck_d), .o_rise(tck_rise), .o_fall(tck_fall)
  );

  // TMS idles high so the TAP sits in TLR while nothing is driven
  tck_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_tms_sync (
    .clk(clk), .reset(reset), .i_d(i_tms),
    .o_s(tms_s), .o_d(tms_d), .o_rise(tms_rise_unused), .o_fall(tms_fall_unused)
  );

  tck_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_tdi_sync (
    .clk(clk), .reset(reset), .i_d(i_tdi),
    .o_s(tdi_s), .o_d(tdi_d_unused), .o_rise(tdi_rise_unused), .o_fall(tdi_fall_unused)
  );

  tap_state_t            state_q, state_d;
  logic [ADDR_WIDTH-1:0] ir_sr_q, ir_sr_d;
  logic [ADDR_WIDTH-1:0] ir_q, ir_d;
  logic [IO_WIDTH-1:0]   dr_q, dr_d;
  logic                  bypass_q, bypass_d;
  logic [IO_WIDTH-1:0]   outbound_q, outbound_d;
  logic                  tdo_q, tdo_d;
  logic                  selected;

  assign selected = (ir_q == address);

  always_comb begin
    state_d    = state_q;
    ir_sr_d    = ir_sr_q;
    ir_d       = ir_q;
    dr_d       = dr_q;
    bypass_d   = bypass_q;
    outbound_d = outbound_q;
    tdo_d      = tdo_q;

    if (tck_rise) begin
      case (state_q)
        CAPTURE_IR: ir_sr_d = ADDR_WIDTH'(IR_CAPTURE);
        SHIFT_IR:   ir_sr_d = {tdi_s, ir_sr_q[ADDR_WIDTH-1:1]};
        CAPTURE_DR: begin
          if (selected) dr_d = inbound;
          else          bypass_d = 1'b0;
        end
        SHIFT_DR: begin
          if (selected) dr_d = {tdi_s, dr_q[IO_WIDTH-1:1]};
          else          bypass_d = tdi_s;
        end
        default: ;
      endcase

      state_d = tap_next(state_q, tms_s);

      // Entry actions take effect on the same edge as the transition
      case (state_d)
        UPDATE_IR: ir_d = ir_sr_q;
        UPDATE_DR: if (selected) outbound_d = dr_q;
        TLR:       ir_d = ADDR_WIDTH'(IR_RESET);
        default: ;
      endcase
    end

    if (tck_fall) begin
      case (state_q)
        SHIFT_IR: tdo_d = ir_sr_q[0];
        SHIFT_DR: tdo_d = selected ? dr_q[0] : bypass_q;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= TLR;
      ir_sr_q    <= '0;
      ir_q       <= ADDR_WIDTH'(IR_RESET);
      dr_q       <= '0;
      bypass_q   <= 1'b0;
      outbound_q <= '0;
      tdo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ir_sr_q    <= ir_sr_d;
      ir_q       <= ir_d;
      dr_q       <= dr_d;
      bypass_q   <= bypass_d;
      outbound_q <= outbound_d;
      tdo_q      <= tdo_d;
    end
  end

  assign outbound = outbound_q;
  assign o_tck    = tck_d;
  assign o_tms    = tms_d;
  assign o_tdo    = tdo_q;

endmodule
`default_nettype wire
